// File: rtl/sd_spi.sv
// sd_spi: IO-bus SPI master for the SD card slot.
// Byte-wide SPI mode 0 transfers, MSB first, programmable half-period divider,
// software-owned chip select and a level interrupt on transfer completion.
module sd_spi #(
    parameter int          DIV_W   = 8,
    parameter int unsigned DIV_RST = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] io_addr,
    input  logic       io_write,
    input  logic       io_read,
    input  logic [7:0] io_wdata,
    output logic [7:0] io_rdata,
    output logic       interrupt,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output logic       cs_n
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;

    localparam logic [DIV_W-1:0] W_DIV_RST = DIV_W'(DIV_RST);

    logic [1:0]       r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_ie;
    logic             r_cs;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic [2:0]       r_bitcnt;
    logic [7:0]       r_tx;
    logic [7:0]       r_rx;
    logic [7:0]       r_data;
    logic             r_miso_s1;
    logic             r_miso_s2;
    logic             r_intr;

    logic w_wr_data;
    logic w_wr_ctrl;
    logic w_wr_div;
    logic w_rd_data;
    logic w_start;
    logic w_cnt_zero;
    logic w_complete;

    assign w_wr_data  = io_write && (io_addr == 4'd0);
    assign w_wr_ctrl  = io_write && (io_addr == 4'd1);
    assign w_wr_div   = io_write && (io_addr == 4'd2);
    assign w_rd_data  = io_read  && (io_addr == 4'd0);
    // A DATA write is only accepted when idle; BUSY stays high through the completion cycle.
    assign w_start    = w_wr_data && !r_busy;
    assign w_cnt_zero = (r_cnt == '0);
    assign w_complete = (r_state == ST_HIGH) && w_cnt_zero && (r_bitcnt == 3'd0);

    assign sclk      = (r_state == ST_HIGH);
    assign mosi      = (r_state == ST_IDLE) ? 1'b1 : r_tx[7];
    assign cs_n      = ~r_cs;
    assign interrupt = r_intr;

    // Combinational register read mux.
    always_comb begin
        io_rdata = '0;
        case (io_addr)
            4'd0:    io_rdata = r_data;
            4'd1:    io_rdata = {4'b0000, r_cs, r_ie, r_done, r_busy};
            4'd2:    io_rdata = 8'(r_div);
            default: io_rdata = '0;
        endcase
    end

    // Two-flop synchroniser for the external miso pin.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_miso_s1 <= 1'b1;
            r_miso_s2 <= 1'b1;
        end else begin
            r_miso_s1 <= miso;
            r_miso_s2 <= r_miso_s1;
        end
    end

    // Software-visible control registers: IE, CS and the clock divider.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ie  <= 1'b0;
            r_cs  <= 1'b0;
            r_div <= W_DIV_RST;
        end else begin
            if (w_wr_ctrl) begin
                r_ie <= io_wdata[2];
                r_cs <= io_wdata[3];
            end
            if (w_wr_div) begin
                r_div <= DIV_W'(io_wdata);
            end
        end
    end

    // Sticky DONE flag; completion outranks every clearing source in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_done <= 1'b0;
        end else if (w_complete) begin
            r_done <= 1'b1;
        end else if (w_start || w_rd_data || (w_wr_ctrl && io_wdata[1])) begin
            r_done <= 1'b0;
        end
    end

    // Registered level interrupt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_intr <= 1'b0;
        end else begin
            r_intr <= r_done & r_ie;
        end
    end

    // Transfer FSM: LOW half samples miso on exit, HIGH half shifts mosi on exit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_bitcnt <= 3'd0;
            r_tx     <= 8'hFF;
            r_rx     <= 8'h00;
            r_data   <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_tx     <= io_wdata;
                        r_busy   <= 1'b1;
                        r_bitcnt <= 3'd7;
                        r_cnt    <= r_div;
                        r_state  <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (w_cnt_zero) begin
                        r_cnt   <= r_div;
                        r_rx    <= {r_rx[6:0], r_miso_s2};
                        r_state <= ST_HIGH;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (w_cnt_zero) begin
                        if (r_bitcnt != 3'd0) begin
                            r_tx     <= {r_tx[6:0], 1'b1};
                            r_bitcnt <= r_bitcnt - 3'd1;
                            r_cnt    <= r_div;
                            r_state  <= ST_LOW;
                        end else begin
                            r_data  <= r_rx;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
